instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Fetch/decode/sequence stage feeding the 8x8 register file and downstream ALU.
//  - Fetches 16-bit instructions from a synchronous instruction ROM.
//  - Splits each instruction into register addresses (A1, A2, Destination) and an opcode.
//  - Sequences each instruction through a multi-cycle FSM with an ALU stall handshake.
// PARAMETERS
//  PC_WIDTH     8   program counter / instruction address width
//  INSTR_WIDTH  16  instruction word width; fixed format below, must be 16
// PORTS
//  CLK          in   1         rising-edge clock
//  RST_N        in   1         asynchronous, active-low reset
//  Start        in   1         1-cycle pulse; begins execution at PC=0 from IDLE/HALTED
//  IAddr        out  PC_WIDTH  instruction ROM address
//  IData        in   16        ROM read data, valid the cycle after IAddr is driven
//  ExecBusy     in   1         ALU stall; high = current op not finished
//  A1           out  3         source register 1 address to register file
//  A2           out  3         source register 2 address to register file
//  Destination  out  3         destination register address
//  Opcode       out  4         decoded opcode to ALU
//  OpValid      out  1         high throughout EXEC; A1/A2/Destination/Opcode stable
//  WriteEn      out  1         1-cycle pulse in WRITEBACK; register file commits Destination
//  Running      out  1         high in any state other than IDLE/HALTED
//  Halted       out  1         high in HALTED
// BEHAVIOUR
//  Instruction format: [15:12] opcode, [11:9] Destination, [8:6] A1, [5:3] A2, [2:0] ignored.
//  JMP only: [7:0] target; upper PC bits, if any, are zeroed.
//  Opcodes: 0x0 NOP; 0x1-0xD ALU ops passed through; 0xE JMP; 0xF HALT.
//  Reset (async, RST_N=0): state IDLE, PC=0, IAddr=0, A1=A2=Destination=0, Opcode=0;
//   OpValid=WriteEn=Running=Halted=0. Reset mid-instruction abandons it.
//   No WriteEn is issued after reset is asserted.
//  FSM, one transition per clock:
//   IDLE:      Start -> FETCH, PC=0.
//   FETCH:     IAddr=PC -> DECODE.
//   DECODE:    latch IData fields into outputs, then:
//              HALT -> HALTED; JMP -> FETCH with PC=target;
//              NOP -> FETCH with PC+1; other opcodes -> EXEC.
//   EXEC:      OpValid=1; stay while ExecBusy=1; ExecBusy=0 -> WRITEBACK.
//              ExecBusy is sampled every EXEC cycle, including the first.
//   WRITEBACK: WriteEn=1 for exactly one cycle; PC=PC+1 -> FETCH.
//   HALTED:    Halted=1; Start -> FETCH, PC=0; otherwise stay.
//  Latency: ALU instruction with no stall = 4 cycles (FETCH, DECODE, EXEC, WRITEBACK).
//   NOP/JMP = 2 cycles.
//  PC arithmetic is modulo 2^PC_WIDTH: PC=255 increments to 0 (wrap, no flag).
//  Start is ignored while Running=1. Start coinciding with reset release is ignored.
//  Decoded outputs hold their last values in FETCH, HALTED and IDLE; only DECODE updates them.
//  OpValid and WriteEn are never high in the same cycle.
// CONFIGURATION
//  SEQ_JUMP_EN defined:   opcode 0xE is JMP as above.
//  SEQ_JUMP_EN undefined: opcode 0xE decodes as NOP (PC+1, no EXEC, no WriteEn).
//   No jump logic is synthesised.
// TESTING
//  1 Reset: RST_N=0 during EXEC with ExecBusy=1 -> all outputs 0 immediately;
//    state IDLE; no WriteEn after release.
//  2 ROM[0]=0x1A50 (op1, D=5, A1=1, A2=2), ExecBusy=0, Start
//    -> DECODE: Destination=5, A1=1, A2=2, Opcode=1.
//    -> OpValid 1 cycle, WriteEn 1 cycle, IAddr=1 next FETCH.
//  3 Same instruction with ExecBusy high 3 cycles -> OpValid high 4 cycles;
//    WriteEn only after ExecBusy falls.
//  4 ROM[0]=0xE0FF (JMP 255), ROM[255]=NOP, ROM[0] on revisit via wrap
//    -> IAddr sequence 0, 255, 0.
//    Without SEQ_JUMP_EN -> IAddr sequence 0, 1.
//  5 ROM[1]=0xF000 -> Halted=1, Running=0, outputs hold.
//    Start -> IAddr=0, Halted=0.
//  6 Start pulsed during EXEC -> ignored; PC and state unchanged.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequence stage: fetches 16-bit instructions from a synchronous ROM and
// steps each through FETCH/DECODE/EXEC/WRITEBACK. Define SEQ_JUMP_EN to enable opcode 0xE as JMP.
module instr_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   Start,
    output logic [PC_WIDTH-1:0]    IAddr,
    input  logic [INSTR_WIDTH-1:0] IData,
    input  logic                   ExecBusy,
    output logic [2:0]             A1,
    output logic [2:0]             A2,
    output logic [2:0]             Destination,
    output logic [3:0]             Opcode,
    output logic                   OpValid,
    output logic                   WriteEn,
    output logic                   Running,
    output logic                   Halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITEBACK,
        S_HALTED
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                armed_q;
    logic [2:0]          a1_q;
    logic [2:0]          a2_q;
    logic [2:0]          dest_q;
    logic [3:0]          opcode_q;
    logic                opValid_q;
    logic                writeEn_q;
    logic                running_q;
    logic                halted_q;

    logic [3:0]          instrOp;
    logic                isNop;
    logic                startOk;
    logic [PC_WIDTH-1:0] pcPlusOne;
    logic                unusedBits;

    assign instrOp   = IData[15:12];
    assign startOk   = Start && armed_q;
    assign pcPlusOne = pc_q + PC_WIDTH'(1);
    assign unusedBits = ^IData[2:0];

`ifdef SEQ_JUMP_EN
    logic [PC_WIDTH-1:0] jumpTarget;
    assign jumpTarget = PC_WIDTH'(IData[7:0]);
    assign isNop      = (instrOp == OP_NOP);
`else
    // Without jump support the JMP encoding is simply another flavour of NOP.
    assign isNop      = (instrOp == OP_NOP) || (instrOp == OP_JMP);
`endif

    // armed_q blocks a Start that arrives on the very first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            armed_q   <= 1'b0;
            a1_q      <= '0;
            a2_q      <= '0;
            dest_q    <= '0;
            opcode_q  <= '0;
            opValid_q <= 1'b0;
            writeEn_q <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (startOk) begin
                        state_q   <= S_FETCH;
                        pc_q      <= '0;
                        running_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    opcode_q <= instrOp;
                    dest_q   <= IData[11:9];
                    a1_q     <= IData[8:6];
                    a2_q     <= IData[5:3];
                    if (instrOp == OP_HALT) begin
                        state_q   <= S_HALTED;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
`ifdef SEQ_JUMP_EN
                    end else if (instrOp == OP_JMP) begin
                        state_q <= S_FETCH;
                        pc_q    <= jumpTarget;
`endif
                    end else if (isNop) begin
                        state_q <= S_FETCH;
                        pc_q    <= pcPlusOne;
                    end else begin
                        state_q   <= S_EXEC;
                        opValid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!ExecBusy) begin
                        state_q   <= S_WRITEBACK;
                        opValid_q <= 1'b0;
                        writeEn_q <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    state_q   <= S_FETCH;
                    writeEn_q <= 1'b0;
                    pc_q      <= pcPlusOne;
                end
                S_HALTED: begin
                    if (startOk) begin
                        state_q   <= S_FETCH;
                        pc_q      <= '0;
                        halted_q  <= 1'b0;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign IAddr       = pc_q;
    assign A1          = a1_q;
    assign A2          = a2_q;
    assign Destination = dest_q;
    assign Opcode      = opcode_q;
    assign OpValid     = opValid_q;
    assign WriteEn     = writeEn_q;
    assign Running     = running_q;
    assign Halted      = halted_q;

endmodule
